// File: rtl/lfsr_prng.sv
// 16-bit Fibonacci LFSR pseudo-random generator.
// Polynomial x^16+x^14+x^13+x^11+1 (taps on bits 0, 2, 3 and 5 of a right-shifting
// register), maximal length 65535. The state steps on every clock edge while rst is
// low. On a reset edge it loads either INIT_SEED or ext_seed. A zero seed is replaced
// by 16'h0001 so the register can never lock up in the all-zero state.
module lfsr_prng #(
  parameter logic [15:0] INIT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        use_ext_seed,
  input  logic [15:0] ext_seed,
  output logic [15:0] random
);

  logic [15:0] state_reg;
  logic [15:0] state_next;
  logic [15:0] step_next;
  logic [15:0] seed_sel;
  logic [15:0] seed_safe;
  logic        feedback;

  // Feedback bit from the four taps of the polynomial.
  assign feedback = state_reg[0] ^ state_reg[2] ^ state_reg[3] ^ state_reg[5];

  // Shift right by one; each lower bit takes its upper neighbour.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_shift
      assign step_next[gi] = state_reg[gi + 1];
    end
  endgenerate

  // The feedback enters at the top of the register.
  assign step_next[15] = feedback;

  // Seed selection is only consumed on reset edges, so these inputs are inert
  // otherwise.
  assign seed_sel  = use_ext_seed ? ext_seed : INIT_SEED;
  assign seed_safe = (seed_sel == 16'h0000) ? 16'h0001 : seed_sel;

  // Next-state choice: reload the guarded seed during reset, otherwise step once.
  always_comb begin
    state_next = step_next;
    if (rst) begin
      state_next = seed_safe;
    end
  end

  // State register. It has no asynchronous init, so it is X until the first reset edge.
  always_ff @(posedge clk) begin
    state_reg <= state_next;
  end

  // The output comes straight from the flop, with no logic after it.
  assign random = state_reg;

endmodule

// File: tb/tb_lfsr_prng.sv
// Testbench for lfsr_prng.
// It runs a table of directed vectors, a hand-written mid-run reset sequence and
// randomized reseed/run sequences checked against a behavioural model. It ends with
// a full-period walk from the default seed.
module tb_lfsr_prng;

  logic        clk;
  logic        rst;
  logic        use_ext_seed;
  logic [15:0] ext_seed;
  logic [15:0] random;

  int vectors;
  int miscompares;

  lfsr_prng #(.INIT_SEED(16'hACE1)) dut (
    .clk          (clk),
    .rst          (rst),
    .use_ext_seed (use_ext_seed),
    .ext_seed     (ext_seed),
    .random       (random)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        use_ext;
    logic [15:0] seed;
    logic [15:0] expected;
  } vec_t;

  // Reference model: the polynomial x^16+x^14+x^13+x^11+1 applied as a list of tap
  // positions on a right-shifting register.
  function automatic logic [15:0] model_step(input logic [15:0] s);
    int taps[4] = '{0, 2, 3, 5};
    logic fb;
    fb = 1'b0;
    foreach (taps[k]) fb = fb ^ s[taps[k]];
    return (s >> 1) | (16'(fb) << 15);
  endfunction

  function automatic logic [15:0] model_seed(input logic ue, input logic [15:0] es);
    logic [15:0] s;
    s = ue ? es : 16'hACE1;
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

  // Apply inputs, clock once, then sample 1 time unit after the edge.
  task automatic cycle(input logic r, input logic ue, input logic [15:0] es);
    rst = r;
    use_ext_seed = ue;
    ext_seed = es;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp, input bit verbose);
    vectors++;
    if (random !== exp) begin
      miscompares++;
      $display("FAIL %s: random=%h expected=%h", name, random, exp);
    end else if (verbose) begin
      $display("ok   %s: random=%h (rst=%b use_ext=%b ext=%h)", name, random, rst,
               use_ext_seed, ext_seed);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  vec_t table_v[$];

  initial begin
    logic [15:0] m;
    int zero_hits;
    int early_hits;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    use_ext_seed = 1'b0;
    ext_seed = 16'h0000;

    // Directed table: each row is one clock edge.
    table_v = '{
      '{1'b1, 1'b0, 16'hFFFF, 16'hACE1},   // default seed
      '{1'b0, 1'b0, 16'h0000, 16'h5670},
      '{1'b0, 1'b0, 16'h0000, 16'hAB38},
      '{1'b0, 1'b0, 16'h0000, 16'h559C},
      '{1'b1, 1'b1, 16'h1234, 16'h1234},   // external seed, reset held two edges
      '{1'b1, 1'b1, 16'h1234, 16'h1234},
      '{1'b0, 1'b0, 16'h0000, 16'h091A},
      '{1'b1, 1'b1, 16'h0000, 16'h0001},   // zero seed is guarded
      '{1'b0, 1'b1, 16'h0000, 16'h8000},
      '{1'b0, 1'b0, 16'hFFFF, 16'h4000},
      '{1'b1, 1'b0, 16'hFFFF, 16'hACE1},   // seed inputs toggled while running
      '{1'b0, 1'b1, 16'hBEEF, 16'h5670},
      '{1'b0, 1'b0, 16'h1111, 16'hAB38},
      '{1'b0, 1'b1, 16'h0000, 16'h559C}
    };
    foreach (table_v[i]) begin
      cycle(table_v[i].rst, table_v[i].use_ext, table_v[i].seed);
      check($sformatf("table[%0d]", i), table_v[i].expected, 1'b1);
    end

    // Mid-run reset: step 10 times from ACE1, then reset and expect the sequence to
    // repeat.
    cycle(1'b1, 1'b0, 16'h0000);
    check("midrun_seed", 16'hACE1, 1'b1);
    m = 16'hACE1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 16'h0000);
      m = model_step(m);
      check($sformatf("midrun_step%0d", i), m, 1'b1);
    end
    cycle(1'b1, 1'b0, 16'h0000);
    check("midrun_reload", 16'hACE1, 1'b1);
    cycle(1'b0, 1'b0, 16'h0000);
    check("midrun_s1", 16'h5670, 1'b1);
    cycle(1'b0, 1'b0, 16'h0000);
    check("midrun_s2", 16'hAB38, 1'b1);
    cycle(1'b0, 1'b0, 16'h0000);
    check("midrun_s3", 16'h559C, 1'b1);

    // Randomized reseed and run sequences checked against the model.
    for (int t = 0; t < 40; t++) begin
      logic        ue;
      logic [15:0] es;
      int          hold;
      int          run;
      ue   = 1'($urandom_range(0, 1));
      es   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      hold = $urandom_range(1, 3);
      run  = $urandom_range(5, 30);
      m = model_seed(ue, es);
      for (int h = 0; h < hold; h++) begin
        cycle(1'b1, ue, es);
        check($sformatf("rnd%0d_reset%0d", t, h), m, 1'b1);
      end
      for (int s = 0; s < run; s++) begin
        cycle(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
        m = model_step(m);
        check($sformatf("rnd%0d_step%0d", t, s), m, 1'b1);
      end
    end

    // Full period from the default seed.
    cycle(1'b1, 1'b0, 16'h0000);
    check("period_seed", 16'hACE1, 1'b1);
    zero_hits = 0;
    early_hits = 0;
    for (int i = 1; i <= 65535; i++) begin
      cycle(1'b0, 1'b0, 16'h0000);
      if (random === 16'h0000) zero_hits++;
      if (i < 65535 && random === 16'hACE1) early_hits++;
    end
    check("period_return", 16'hACE1, 1'b1);
    check_int("period_zero_states", zero_hits, 0);
    check_int("period_early_returns", early_hits, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
